// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the async FIFO: round-robin between two 1- or 2-byte
// message sources, serialising each captured message byte-by-byte into the FIFO.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    w_clk,
  input  logic                    w_rstn,
  input  logic                    req0_valid,
  input  logic [2*DATA_WIDTH-1:0] req0_data,
  input  logic                    req0_len,
  output logic                    req0_ack,
  input  logic                    req1_valid,
  input  logic [2*DATA_WIDTH-1:0] req1_data,
  input  logic                    req1_len,
  output logic                    req1_ack,
  input  logic                    full,
  output logic                    w_inc,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    busy
);

  // Handshake: a requester holds valid/data/len stable until its one-cycle ack;
  // the ack cycle is the first BYTE0 cycle, and on the edge ending it the
  // requester drops valid or presents its next message. The FIFO side is
  // valid-only: a byte is written in any BYTE0/BYTE1 cycle where full is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    len_q, len_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    ack0_q, ack0_d;
  logic                    ack1_q, ack1_d;
  logic                    grant1;

  // ptr_q = 1 means req1 is preferred when both requesters are valid.
  always_comb grant1 = req1_valid && (!req0_valid || ptr_q);

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state_q   <= IDLE;
      ptr_q     <= 1'b0;
      len_q     <= 1'b0;
      hi_q      <= '0;
      wr_data_q <= '0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      len_q     <= len_d;
      hi_q      <= hi_d;
      wr_data_q <= wr_data_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    hi_d      = hi_q;
    wr_data_d = wr_data_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = BYTE0;
          ptr_d   = !grant1;
          ack0_d  = !grant1;
          ack1_d  = grant1;
          if (grant1) begin
            wr_data_d = req1_data[DATA_WIDTH-1:0];
            hi_d      = req1_data[2*DATA_WIDTH-1:DATA_WIDTH];
            len_d     = req1_len;
          end else begin
            wr_data_d = req0_data[DATA_WIDTH-1:0];
            hi_d      = req0_data[2*DATA_WIDTH-1:DATA_WIDTH];
            len_d     = req0_len;
          end
        end
      end
      BYTE0: begin
        if (!full) begin
          if (len_q) begin
            wr_data_d = hi_q;
            state_d   = BYTE1;
          end else begin
            state_d   = IDLE;
          end
        end
      end
      BYTE1: begin
        if (!full) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // w_inc stays combinational so a full asserted mid-cycle blocks the write at once.
  assign w_inc    = (state_q == BYTE0 || state_q == BYTE1) && !full;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != IDLE);
  assign req0_ack = ack0_q;
  assign req1_ack = ack1_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic, compared against a message-level round-robin model with a byte queue.
module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic          w_clk = 1'b0;
  logic          w_rstn;
  logic          req0_valid, req1_valid;
  logic [2*DW-1:0] req0_data, req1_data;
  logic          req0_len, req1_len;
  logic          req0_ack, req1_ack;
  logic          full;
  logic          w_inc;
  logic [DW-1:0] wr_data;
  logic          busy;

  fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (
    .w_clk      (w_clk),
    .w_rstn     (w_rstn),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_len   (req0_len),
    .req0_ack   (req0_ack),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_len   (req1_len),
    .req1_ack   (req1_ack),
    .full       (full),
    .w_inc      (w_inc),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  // ---------------- clock ----------------
  always #5 w_clk = ~w_clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Message-level view: when idle and someone is valid, pick the winner by the
  // round-robin rule, queue its bytes, and expect one byte per non-full cycle.
  logic [DW-1:0] exp_q[$];
  int            bytes_left = 0;
  int            pref       = 0;
  logic          exp_ack0   = 1'b0;
  logic          exp_ack1   = 1'b0;

  always @(negedge w_clk) begin
    if (!w_rstn) begin
      check("rst_w_inc", w_inc, 0);
      check("rst_busy", busy, 0);
      check("rst_ack0", req0_ack, 0);
      check("rst_ack1", req1_ack, 0);
      check("rst_wr_data", wr_data, 0);
      exp_q.delete();
      bytes_left = 0;
      pref       = 0;
      exp_ack0   = 1'b0;
      exp_ack1   = 1'b0;
    end else begin
      check("busy", busy, bytes_left != 0);
      check("w_inc", w_inc, (bytes_left != 0) && !full);
      check("ack0", req0_ack, exp_ack0);
      check("ack1", req1_ack, exp_ack1);
      exp_ack0 = 1'b0;
      exp_ack1 = 1'b0;
      if (bytes_left != 0) begin
        if (exp_q.size() != 0) begin
          check("wr_data", wr_data, exp_q[0]);
          if (!full) begin
            void'(exp_q.pop_front());
            bytes_left--;
          end
        end
      end else if (req0_valid || req1_valid) begin
        int who;
        logic [2*DW-1:0] d;
        logic l;
        if (req0_valid && req1_valid) who = pref;
        else who = req1_valid ? 1 : 0;
        d = (who == 1) ? req1_data : req0_data;
        l = (who == 1) ? req1_len : req0_len;
        exp_q.push_back(d[DW-1:0]);
        if (l) exp_q.push_back(d[2*DW-1:DW]);
        bytes_left = l ? 2 : 1;
        pref       = 1 - who;
        exp_ack0   = (who == 0);
        exp_ack1   = (who == 1);
      end
    end
  end

  // ---------------- driver ----------------
  logic rand_en = 1'b0;
  logic hold_en = 1'b0;

  // One clock: sample acks mid-cycle, then update inputs just after the edge.
  task automatic cycle();
    logic a0, a1;
    @(negedge w_clk);
    a0 = req0_ack;
    a1 = req1_ack;
    @(posedge w_clk);
    #1;
    if (a0 && !hold_en) req0_valid = 1'b0;
    if (a1 && !hold_en) req1_valid = 1'b0;
    if (rand_en) begin
      if (!req0_valid && $urandom_range(0, 99) < 40) begin
        req0_data  = 16'($urandom_range(0, 65535));
        req0_len   = 1'($urandom_range(0, 1));
        req0_valid = 1'b1;
      end
      if (!req1_valid && $urandom_range(0, 99) < 40) begin
        req1_data  = 16'($urandom_range(0, 65535));
        req1_len   = 1'($urandom_range(0, 1));
        req1_valid = 1'b1;
      end
      full = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    w_rstn     = 1'b0;
    full       = 1'b0;
    req0_valid = 1'b1; req0_data = 16'h12AB; req0_len = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h3456; req1_len = 1'b1;

    // reset with both valid: req0 wins first, then req1 sends 0x56, 0x34
    repeat (3) @(negedge w_clk);
    @(posedge w_clk);
    #1 w_rstn = 1'b1;
    run(8);

    // both valid continuously with 1-byte messages: strict alternation
    hold_en = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h0001; req0_len = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h0002; req1_len = 1'b0;
    run(12);
    hold_en = 1'b0;
    run(6);

    // full held for 3 cycles during BYTE1 of 0xBEEF
    req1_valid = 1'b1; req1_data = 16'hBEEF; req1_len = 1'b1;
    cycle();          // now BYTE0
    cycle();          // now BYTE1, 0xEF written
    full = 1'b1;
    run(3);
    full = 1'b0;
    run(3);

    // reset pulse in BYTE1 after a req0 grant (pointer would favour req1)
    req0_valid = 1'b1; req0_data = 16'hBEEF; req0_len = 1'b1;
    cycle();
    cycle();          // now BYTE1
    w_rstn = 1'b0;
    #1;
    check("rst_mid_w_inc", w_inc, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge w_clk);
    @(posedge w_clk);
    #1;
    w_rstn = 1'b1;
    req0_valid = 1'b1; req0_data = 16'h0011; req0_len = 1'b0;
    req1_valid = 1'b1; req1_data = 16'h0022; req1_len = 1'b0;
    run(8);

    // randomized traffic with random backpressure
    rand_en = 1'b1;
    run(3000);
    rand_en = 1'b0;
    full    = 1'b0;
    run(12);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
